// File: rtl/tt_vector_player.sv
// Vector stimulus/response engine: stores stimulus, expected and mask vectors, replays
// them onto a DUT input bus and checks the DUT output under a mask after LAT cycles.
module tt_vector_player #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int LAT   = 1,
   parameter int ERRW  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ena,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [WIDTH-1:0]         load_stim,
   input  logic [WIDTH-1:0]         load_exp,
   input  logic [WIDTH-1:0]         load_mask,
   input  logic                     start,
   input  logic                     clear,
   input  logic                     loop_en,
   output logic [WIDTH-1:0]         dut_in,
   input  logic [WIDTH-1:0]         dut_out,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [ERRW-1:0]          err_count,
   output logic [$clog2(DEPTH)-1:0] fail_index,
   output logic [WIDTH-1:0]         fail_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(LAT - 1);
   localparam logic [AW:0]   FULL       = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] stim_mem [DEPTH];
   logic [WIDTH-1:0] exp_mem  [DEPTH];
   logic [WIDTH-1:0] mask_mem [DEPTH];

   logic [AW-1:0]   index;
   logic [PW-1:0]   phase;
   logic            do_start;
   logic            do_sample;
   logic            is_last;
   logic            mismatch;
   logic [ERRW-1:0] err_next;

   assign busy     = (state == RUN);
   assign is_last  = ({1'b0, index} == (count - 1'b1));
   assign mismatch = |((dut_out ^ exp_mem[index]) & mask_mem[index]);
   assign err_next = (mismatch && (err_count != '1)) ? err_count + 1'b1 : err_count;

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      do_start   = 1'b0;
      do_sample  = 1'b0;
      if (ena) begin
         if (clear) begin
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  load_ready = !start && (count != FULL);
                  if (start && (count != '0)) begin
                     do_start  = 1'b1;
                     state_nxt = RUN;
                  end
               end
               RUN: begin
                  if (phase == PHASE_LAST) begin
                     do_sample = 1'b1;
                     if (is_last && !loop_en) state_nxt = DONE;
                  end
               end
               DONE: begin
                  if (start && (count != '0)) begin
                     do_start  = 1'b1;
                     state_nxt = RUN;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Vector store has no reset; count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (load_ready && load_valid) begin
         stim_mem[count[AW-1:0]] <= load_stim;
         exp_mem[count[AW-1:0]]  <= load_exp;
         mask_mem[count[AW-1:0]] <= load_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         dut_in     <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_index <= '0;
         fail_data  <= '0;
         index      <= '0;
         phase      <= '0;
      end else if (ena) begin
         if (clear) begin
            count  <= '0;
            dut_in <= '0;
            done   <= 1'b0;
            pass   <= 1'b0;
         end else if (do_start) begin
            err_count  <= '0;
            fail_index <= '0;
            fail_data  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            index      <= '0;
            phase      <= '0;
            dut_in     <= stim_mem[AW'(0)];
         end else if (load_ready && load_valid) begin
            count <= count + 1'b1;
         end else if (state == RUN) begin
            if (do_sample) begin
               err_count <= err_next;
               // A zero count means no mismatch yet; saturation never wraps back to zero.
               if (mismatch && (err_count == '0)) begin
                  fail_index <= index;
                  fail_data  <= dut_out;
               end
               phase <= '0;
               if (is_last) begin
                  if (loop_en) begin
                     index  <= '0;
                     dut_in <= stim_mem[AW'(0)];
                  end else begin
                     done <= 1'b1;
                     pass <= (err_next == '0);
                  end
               end else begin
                  index  <= index + 1'b1;
                  dut_in <= stim_mem[index + 1'b1];
               end
            end else begin
               phase <= phase + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tt_vector_player.sv
// Directed bench for tt_vector_player: a LAT=1 instance with combinational loopback
// and a LAT=3 instance driven by a register-delay DUT model.
module tb_tt_vector_player;

   logic clk;
   logic rst_n;

   logic       ena, load_valid, load_ready, start, clear, loop_en, busy, done, pass;
   logic [7:0] load_stim, load_exp, load_mask, dut_in, dut_out, err_count, fail_data;
   logic [2:0] fail_index;
   logic [3:0] count;

   logic       ena_b, load_valid_b, load_ready_b, start_b, clear_b, loop_en_b, busy_b, done_b, pass_b;
   logic [7:0] load_stim_b, load_exp_b, load_mask_b, dut_in_b, dut_out_b, err_count_b, fail_data_b;
   logic [2:0] fail_index_b;
   logic [3:0] count_b;
   logic [7:0] d1_b, d2_b, d3_b;
   logic       slow_b;

   int vectors;
   int miscompares;

   tt_vector_player #(.WIDTH(8), .DEPTH(8), .LAT(1), .ERRW(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .load_valid(load_valid), .load_ready(load_ready),
      .load_stim(load_stim), .load_exp(load_exp), .load_mask(load_mask), .start(start),
      .clear(clear), .loop_en(loop_en), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
      .done(done), .pass(pass), .err_count(err_count), .fail_index(fail_index),
      .fail_data(fail_data), .count(count)
   );

   tt_vector_player #(.WIDTH(8), .DEPTH(8), .LAT(3), .ERRW(8)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .ena(ena_b), .load_valid(load_valid_b), .load_ready(load_ready_b),
      .load_stim(load_stim_b), .load_exp(load_exp_b), .load_mask(load_mask_b), .start(start_b),
      .clear(clear_b), .loop_en(loop_en_b), .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b),
      .done(done_b), .pass(pass_b), .err_count(err_count_b), .fail_index(fail_index_b),
      .fail_data(fail_data_b), .count(count_b)
   );

   assign dut_out = dut_in;

   // Two stages put a vector on dut_out exactly LAT=3 edges after it is driven; three is one edge late.
   always @(posedge clk) begin
      d1_b <= dut_in_b;
      d2_b <= d1_b;
      d3_b <= d2_b;
   end
   assign dut_out_b = slow_b ? d3_b : d2_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
      load_valid = 1'b1; load_stim = s; load_exp = e; load_mask = m;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic load_b(input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
      load_valid_b = 1'b1; load_stim_b = s; load_exp_b = e; load_mask_b = m;
      tick();
      load_valid_b = 1'b0;
   endtask

   task automatic clear_a();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic start_a();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (2) tick();
      vectors++; if (dut_in !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dut_in got %h want 00", dut_in); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      vectors++; if (done !== 1'b0 || pass !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done_pass got %b%b want 00", done, pass); end
      vectors++; if (err_count !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_err got %h want 00", err_count); end
      vectors++; if (fail_index !== 3'd0 || fail_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_fail got %0d/%h want 0/00", fail_index, fail_data); end
      vectors++; if (count !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_load_ready got %b want 1", load_ready); end
      vectors++; if (busy_b !== 1'b0 || count_b !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_b got %b/%0d want 0/0", busy_b, count_b); end
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_loopback();
      logic [7:0] s [4];
      s = '{8'h01, 8'h02, 8'h04, 8'h08};
      for (int i = 0; i < 4; i++) load_a(s[i], s[i], 8'hFF);
      vectors++; if (count !== 4'd4) begin miscompares++; $display("[TB] FAIL lb_count got %0d want 4", count); end
      start_a();
      for (int k = 0; k < 4; k++) begin
         vectors++; if (dut_in !== s[k] || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_step%0d got %h/%b want %h/1", k, dut_in, busy, s[k]); end
         tick();
      end
      vectors++; if (done !== 1'b1 || pass !== 1'b1) begin miscompares++; $display("[TB] FAIL lb_done_pass got %b%b want 11", done, pass); end
      vectors++; if (err_count !== 8'h00 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_err_busy got %h/%b want 00/0", err_count, busy); end
      vectors++; if (dut_in !== 8'h08) begin miscompares++; $display("[TB] FAIL lb_hold got %h want 08", dut_in); end
   endtask

   task automatic test_mismatch();
      logic [7:0] s [4];
      s = '{8'h01, 8'h02, 8'h04, 8'h08};
      clear_a();
      vectors++; if (count !== 4'd0 || dut_in !== 8'h00 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL mm_clear got %0d/%h/%b want 0/00/0", count, dut_in, done); end
      for (int i = 0; i < 4; i++) load_a(s[i], (i == 2) ? 8'h05 : s[i], 8'hFF);
      start_a();
      repeat (4) tick();
      vectors++; if (done !== 1'b1 || pass !== 1'b0) begin miscompares++; $display("[TB] FAIL mm_done_pass got %b%b want 10", done, pass); end
      vectors++; if (err_count !== 8'd1) begin miscompares++; $display("[TB] FAIL mm_err got %h want 01", err_count); end
      vectors++; if (fail_index !== 3'd2 || fail_data !== 8'h04) begin miscompares++; $display("[TB] FAIL mm_fail got %0d/%h want 2/04", fail_index, fail_data); end
      clear_a();
      vectors++; if (err_count !== 8'd1 || fail_index !== 3'd2) begin miscompares++; $display("[TB] FAIL mm_clear_hold got %h/%0d want 01/2", err_count, fail_index); end
      for (int i = 0; i < 4; i++) load_a(s[i], (i == 2) ? 8'h05 : s[i], (i == 2) ? 8'hF0 : 8'hFF);
      start_a();
      vectors++; if (err_count !== 8'd0 || fail_index !== 3'd0) begin miscompares++; $display("[TB] FAIL mm_start_clr got %h/%0d want 00/0", err_count, fail_index); end
      repeat (4) tick();
      vectors++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL mm_masked got %b%b/%h want 11/00", done, pass, err_count); end
   endtask

   task automatic test_start_ignored();
      clear_a();
      start_a();
      vectors++; if (busy !== 1'b0 || dut_in !== 8'h00) begin miscompares++; $display("[TB] FAIL si_empty got %b/%h want 0/00", busy, dut_in); end
      load_a(8'h01, 8'h01, 8'hFF);
      load_a(8'h02, 8'h02, 8'hFF);
      load_a(8'h04, 8'h04, 8'hFF);
      load_a(8'h08, 8'h08, 8'hFF);
      start_a();
      tick();
      start_a();
      vectors++; if (dut_in !== 8'h04) begin miscompares++; $display("[TB] FAIL si_run got %h want 04", dut_in); end
      repeat (2) tick();
      vectors++; if (done !== 1'b1 || pass !== 1'b1) begin miscompares++; $display("[TB] FAIL si_done got %b%b want 11", done, pass); end
   endtask

   task automatic test_full();
      clear_a();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) begin
            vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_ready7 got %b want 1", load_ready); end
         end
         load_a(8'(i + 1), 8'(i + 1), 8'hFF);
      end
      vectors++; if (count !== 4'd8 || load_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_8 got %0d/%b want 8/0", count, load_ready); end
      load_a(8'hAA, 8'hAA, 8'hFF);
      vectors++; if (count !== 4'd8) begin miscompares++; $display("[TB] FAIL full_9th got %0d want 8", count); end
   endtask

   task automatic test_loop_saturate();
      logic [7:0] s [4];
      s = '{8'h01, 8'h02, 8'h04, 8'h08};
      clear_a();
      for (int i = 0; i < 4; i++) load_a(s[i], ~s[i], 8'hFF);
      loop_en = 1'b1;
      start_a();
      repeat (254) tick();
      vectors++; if (err_count !== 8'hFE || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_254 got %h/%b want FE/1", err_count, busy); end
      repeat (46) tick();
      vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("[TB] FAIL sat_300 got %h want FF", err_count); end
      vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL sat_loop got %b/%b want 0/1", done, busy); end
      vectors++; if (fail_index !== 3'd0 || fail_data !== 8'h01) begin miscompares++; $display("[TB] FAIL sat_first got %0d/%h want 0/01", fail_index, fail_data); end
      clear_a();
      loop_en = 1'b0;
      vectors++; if (busy !== 1'b0 || dut_in !== 8'h00 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL sat_clear got %b/%h/%0d want 0/00/0", busy, dut_in, count); end
      vectors++; if (err_count !== 8'hFF) begin miscompares++; $display("[TB] FAIL sat_clear_err got %h want FF", err_count); end
   endtask

   task automatic test_ena_freeze();
      clear_a();
      load_a(8'h01, 8'h01, 8'hFF);
      load_a(8'h02, 8'h02, 8'hFF);
      load_a(8'h04, 8'h04, 8'hFF);
      load_a(8'h08, 8'h08, 8'hFF);
      start_a();
      tick();
      ena = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++; if (dut_in !== 8'h02 || busy !== 1'b1 || load_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ena_frozen%0d got %h/%b/%b want 02/1/0", i, dut_in, busy, load_ready); end
      end
      ena = 1'b1;
      tick();
      vectors++; if (dut_in !== 8'h04) begin miscompares++; $display("[TB] FAIL ena_resume got %h want 04", dut_in); end
      repeat (2) tick();
      vectors++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) begin miscompares++; $display("[TB] FAIL ena_done got %b%b/%h want 11/00", done, pass, err_count); end
   endtask

   task automatic test_async_reset();
      clear_a();
      load_a(8'h01, 8'hFE, 8'hFF);
      load_a(8'h02, 8'hFD, 8'hFF);
      load_a(8'h04, 8'hFB, 8'hFF);
      load_a(8'h08, 8'hF7, 8'hFF);
      start_a();
      repeat (2) tick();
      vectors++; if (err_count !== 8'd2 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL ar_pre got %h/%b want 02/1", err_count, busy); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (dut_in !== 8'h00 || busy !== 1'b0 || err_count !== 8'h00) begin miscompares++; $display("[TB] FAIL ar_async got %h/%b/%h want 00/0/00", dut_in, busy, err_count); end
      vectors++; if (fail_data !== 8'h00 || count !== 4'd0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_fields got %h/%0d/%b want 00/0/0", fail_data, count, done); end
      #2 rst_n = 1'b1;
      tick();
      vectors++; if (busy !== 1'b0 || count !== 4'd0) begin miscompares++; $display("[TB] FAIL ar_after got %b/%0d want 0/0", busy, count); end
   endtask

   task automatic test_lat3();
      int cycles;
      logic [7:0] s [4];
      s = '{8'h01, 8'h02, 8'h04, 8'h08};
      slow_b = 1'b0;
      for (int i = 0; i < 4; i++) load_b(s[i], s[i], 8'hFF);
      start_b = 1'b1; tick(); start_b = 1'b0;
      repeat (2) tick();
      vectors++; if (dut_in_b !== 8'h01) begin miscompares++; $display("[TB] FAIL l3_hold got %h want 01", dut_in_b); end
      tick();
      vectors++; if (dut_in_b !== 8'h02) begin miscompares++; $display("[TB] FAIL l3_step got %h want 02", dut_in_b); end
      cycles = 3;
      while (done_b !== 1'b1 && cycles < 50) begin tick(); cycles++; end
      vectors++; if (done_b !== 1'b1 || cycles != 12) begin miscompares++; $display("[TB] FAIL l3_done got %b after %0d want 1 after 12", done_b, cycles); end
      vectors++; if (pass_b !== 1'b1 || err_count_b !== 8'd0) begin miscompares++; $display("[TB] FAIL l3_pass got %b/%h want 1/00", pass_b, err_count_b); end
      slow_b = 1'b1;
      start_b = 1'b1; tick(); start_b = 1'b0;
      cycles = 1;
      while (done_b !== 1'b1 && cycles < 50) begin tick(); cycles++; end
      vectors++; if (done_b !== 1'b1 || pass_b !== 1'b0) begin miscompares++; $display("[TB] FAIL l3s_done got %b%b want 10", done_b, pass_b); end
      vectors++; if (err_count_b !== 8'd4) begin miscompares++; $display("[TB] FAIL l3s_err got %h want 04", err_count_b); end
      vectors++; if (fail_index_b !== 3'd0 || fail_data_b !== 8'h08) begin miscompares++; $display("[TB] FAIL l3s_fail got %0d/%h want 0/08", fail_index_b, fail_data_b); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b1;
      ena = 1'b1; load_valid = 1'b0; start = 1'b0; clear = 1'b0; loop_en = 1'b0;
      load_stim = '0; load_exp = '0; load_mask = '0;
      ena_b = 1'b1; load_valid_b = 1'b0; start_b = 1'b0; clear_b = 1'b0; loop_en_b = 1'b0;
      load_stim_b = '0; load_exp_b = '0; load_mask_b = '0; slow_b = 1'b0;
      test_reset();
      test_loopback();
      test_mismatch();
      test_start_ignored();
      test_full();
      test_loop_saturate();
      test_ena_freeze();
      test_async_reset();
      test_lat3();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
